mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus (address / write-enable / data-out from the CPU, data-in and io_buffer_full back to it).
- Contains the program/data RAM and the memory-mapped I/O registers, and buffers UART transmit and receive bytes in FIFOs.
- Read data is returned one cycle after the request. Writes complete in the same cycle.
- Sits between the CPU core and the UART serializer in the top-level wrapper.

---
 rtl/mem_io_responder.sv | 182 ++++++++++++++++++
 tb/tb_mem_io_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: program/data RAM, memory-mapped I/O
// (UART TX/RX FIFOs, cycle-counter snapshot, stop flag). Reads return one
// cycle after the request; writes land at the same edge.
module mem_io_responder #(
  parameter int RAM_AW       = 17,
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int TX_DEPTH = 2 ** TX_DEPTH_LOG;
  localparam int RX_DEPTH = 2 ** RX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] TX_FULL   = (TX_DEPTH_LOG + 1)'(TX_DEPTH);
  localparam logic [TX_DEPTH_LOG:0] TX_THRESH = (TX_DEPTH_LOG + 1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RX_DEPTH_LOG:0] RX_FULL   = (RX_DEPTH_LOG + 1)'(RX_DEPTH);

  // Address decode (only bits 17:0 take part)
  logic [17:0]       addr;
  logic              io;
  logic              is_data_reg;
  logic              is_snap;
  logic              is_snap0;
  logic [RAM_AW-1:0] idx;
  logic              unused_addr_bits;

  assign addr             = cpu_a[17:0];
  assign io               = (addr[17:16] == 2'b11);
  assign is_data_reg      = (addr == 18'h30000);
  assign is_snap          = (addr[17:2] == 16'hC001);
  assign is_snap0         = (addr == 18'h30004);
  assign idx              = cpu_a[RAM_AW-1:0];
  assign unused_addr_bits = ^cpu_a[31:18];

  logic [7:0]  ram [2 ** RAM_AW];
  logic [31:0] cyc_cnt;
  logic [31:0] snap;

  // TX FIFO state
  logic [7:0]              tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_DEPTH_LOG:0]   tx_count;
  logic                    tx_push_req, tx_push, tx_pop, tx_full;
  logic [7:0]              tx_push_data;

  // RX FIFO state
  logic [7:0]              rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_DEPTH_LOG:0]   rx_count;
  logic                    rx_push, rx_pop, rx_full, rx_empty;

  logic [7:0] rd_next;

  assign tx_full        = (tx_count == TX_FULL);
  assign tx_valid       = (tx_count != '0);
  assign tx_data        = tx_mem[tx_rd_ptr];
  assign io_buffer_full = (tx_count >= TX_THRESH);
  assign tx_pop         = !rst_in && tx_valid && tx_ready;
  // A write to the stop register also queues a 0x00 byte so the host sees the end.
  assign tx_push_req    = !rst_in && cpu_wr && io &&
                          ((is_data_reg && (cpu_dout != 8'h00)) || is_snap0);
  assign tx_push_data   = is_snap0 ? 8'h00 : cpu_dout;
  assign tx_push        = tx_push_req && (!tx_full || tx_pop);

  assign rx_full  = (rx_count == RX_FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_pop   = !rst_in && !cpu_wr && is_data_reg && !rx_empty;
  assign rx_push  = !rst_in && rx_valid && (!rx_full || rx_pop);

  // RAM write port; RAM contents survive reset, requests during reset are dropped
  always_ff @(posedge clk_in) begin
    if (!rst_in && cpu_wr && !io) ram[idx] <= cpu_dout;
  end

  // Read-data selection for the registered response
  always_comb begin
    rd_next = cpu_din;
    if (!cpu_wr) begin
      if (!io) begin
        rd_next = ram[idx];
      end else if (is_data_reg) begin
        rd_next = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      end else if (is_snap) begin
        case (addr[1:0])
          2'd0:    rd_next = cyc_cnt[7:0];
          2'd1:    rd_next = snap[15:8];
          2'd2:    rd_next = snap[23:16];
          default: rd_next = snap[31:24];
        endcase
      end else begin
        rd_next = 8'h00;
      end
    end
  end

  // Registered read response
  always_ff @(posedge clk_in) begin
    if (rst_in) cpu_din <= 8'h00;
    else        cpu_din <= rd_next;
  end

  // Free-running cycle counter and the snapshot taken by reading byte 0
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_cnt <= 32'd0;
      snap    <= 32'd0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (!cpu_wr && is_snap0) snap <= cyc_cnt;
    end
  end

  // Sticky status flags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prog_stop   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (cpu_wr && is_snap0)       prog_stop   <= 1'b1;
      if (tx_push_req && !tx_push)  tx_overflow <= 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_DEPTH_LOG + 1)'(1);
        2'b01:   tx_count <= tx_count - (TX_DEPTH_LOG + 1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_DEPTH_LOG + 1)'(1);
        2'b01:   rx_count <= rx_count - (RX_DEPTH_LOG + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, snapshot, reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        prog_stop;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .prog_stop      (prog_stop),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b1; cpu_dout = d;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_a = a; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tick();
  endtask

  task automatic idle();
    rd(32'h0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    tick();
    tick();
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_buf_full", io_buffer_full, 1'b0);
    check("rst_prog_stop", prog_stop, 1'b0);
    check("rst_tx_ovf", tx_overflow, 1'b0);
    rst_in = 1'b0;

    // RAM write then read-after-write
    wr(32'h10, 8'hA5);
    rd(32'h10);
    check("ram_raw_10", cpu_din, 8'hA5);
    wr(32'h1FFFF, 8'h3C);
    rd(32'h1FFFF);
    check("ram_raw_1ffff", cpu_din, 8'h3C);
    wr(32'h10000, 8'h5A);
    wr(32'h20, 8'h77);

    // TX stream with a zero byte that must be ignored
    tx_ready = 1'b1;
    wr(32'h30000, 8'h41);
    check("tx_first_valid", tx_valid, 1'b1);
    check("tx_first_data", tx_data, 8'h41);
    wr(32'h30000, 8'h00);
    check("tx_zero_ignored", tx_valid, 1'b0);
    wr(32'h30000, 8'h42);
    check("tx_second_valid", tx_valid, 1'b1);
    check("tx_second_data", tx_data, 8'h42);
    idle();
    check("tx_drained", tx_valid, 1'b0);
    check("tx_ovf_clear", tx_overflow, 1'b0);

    // Fill the TX FIFO with the transmitter stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(32'h30000, 8'(i + 1));
      check($sformatf("buf_full_%0d", i + 1), io_buffer_full, (i + 1) >= 14);
    end
    check("tx_no_ovf_at_16", tx_overflow, 1'b0);
    wr(32'h30000, 8'h11);
    check("tx_ovf_at_17", tx_overflow, 1'b1);
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_valid_%0d", i), tx_valid, 1'b1);
      check($sformatf("drain_data_%0d", i), tx_data, 8'(i + 1));
      tick();
    end
    check("drain_empty", tx_valid, 1'b0);
    check("drain_buf_full", io_buffer_full, 1'b0);
    check("ovf_sticky", tx_overflow, 1'b1);
    tx_ready = 1'b0;
    rd(32'h10000);
    check("io_write_no_ram_alias", cpu_din, 8'h5A);

    // RX FIFO: pushes, pops, empty read, simultaneous push and pop
    rx_valid = 1'b1; rx_data = 8'h31; idle();
    rx_data = 8'h32; idle();
    rx_valid = 1'b0;
    rd(32'h30000);
    check("rx_pop_31", cpu_din, 8'h31);
    rd(32'h30000);
    check("rx_pop_32", cpu_din, 8'h32);
    rd(32'h30000);
    check("rx_empty_00", cpu_din, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h33; idle();
    rx_data = 8'h34; rd(32'h30000);
    check("rx_pushpop_33", cpu_din, 8'h33);
    rx_valid = 1'b0;
    rd(32'h30000);
    check("rx_pushpop_34", cpu_din, 8'h34);
    rd(32'h30000);
    check("rx_pushpop_empty", cpu_din, 8'h00);

    // Stop write, then reset mid-stream with a RAM write in the reset cycle
    rd(32'h10);
    check("pre_stop_read", cpu_din, 8'hA5);
    wr(32'h30004, 8'h99);
    check("stop_set", prog_stop, 1'b1);
    check("stop_tx_valid", tx_valid, 1'b1);
    check("stop_tx_zero", tx_data, 8'h00);
    rst_in = 1'b1;
    cpu_a = 32'h10; cpu_wr = 1'b1; cpu_dout = 8'hEE;
    tick();
    rst_in = 1'b0;
    check("post_rst_stop", prog_stop, 1'b0);
    check("post_rst_tx_valid", tx_valid, 1'b0);
    check("post_rst_cpu_din", cpu_din, 8'h00);
    check("post_rst_ovf", tx_overflow, 1'b0);
    rd(32'h10);
    check("ram_kept_10", cpu_din, 8'hA5);
    rd(32'h20);
    check("ram_kept_20", cpu_din, 8'h77);

    // Counter snapshot: counter equals 0x1FF when the byte-0 read is sampled
    do_reset();
    repeat (511) idle();
    rd(32'h30004);
    check("snap_b0", cpu_din, 8'hFF);
    rd(32'h30005);
    check("snap_b1", cpu_din, 8'h01);
    rd(32'h30006);
    check("snap_b2", cpu_din, 8'h00);
    rd(32'h30007);
    check("snap_b3", cpu_din, 8'h00);
    rd(32'h30008);
    check("io_other_read", cpu_din, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
